latch_input_conditioner: RTL and testbench

LATCH_INPUT_CONDITIONER -- requirements
Module: latch_input_conditioner

---
 rtl/latch_cond_pkg.sv | 15 +
 rtl/debounce_ch.sv | 86 ++++++++
 rtl/latch_input_conditioner.sv | 84 ++++++++
 tb/tb_latch_input_conditioner.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/latch_cond_pkg.sv
// Shared types and sizing helpers for the latch input conditioner.
package latch_cond_pkg;

    typedef enum logic {
        STABLE   = 1'b0,
        CHANGING = 1'b1
    } chanState_e;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

    function automatic int cntWidth(input int debounceCycles);
        return $clog2(debounceCycles + 1);
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One conditioning channel: two-flop synchronizer followed by a counting debouncer.
module debounce_ch
    import latch_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic deb
);

    localparam int CW = cntWidth(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(DEBOUNCE_CYCLES);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_deb;
    logic [CW-1:0] r_cnt;
    chanState_e    r_state;

    logic          w_differ;
    logic [CW-1:0] w_cntInc;
    logic [CW-1:0] w_cntNext;
    logic          w_debNext;
    chanState_e    w_stateNext;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= STABLE;
            r_cnt   <= '0;
            r_deb   <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_deb   <= w_debNext;
        end
    end

    assign w_differ = (r_sync2 != r_deb);
    assign w_cntInc = r_cnt + CW'(1);

    // The sample that makes the run reach DEBOUNCE_CYCLES is accepted on that same edge.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_debNext   = r_deb;
        case (r_state)
            STABLE: begin
                if (w_differ) begin
                    w_stateNext = CHANGING;
                    w_cntNext   = CW'(1);
                end
            end
            CHANGING: begin
                if (!w_differ) begin
                    w_stateNext = STABLE;
                    w_cntNext   = '0;
                end else if (w_cntInc == CNT_LIMIT) begin
                    w_stateNext = STABLE;
                    w_cntNext   = '0;
                    w_debNext   = r_sync2;
                end else begin
                    w_cntNext   = w_cntInc;
                end
            end
            default: begin
                w_stateNext = STABLE;
                w_cntNext   = '0;
            end
        endcase
    end

    assign deb = r_deb;

endmodule

// File: rtl/latch_input_conditioner.sv
// Debounces set/reset/preset/clear requests, arbitrates them and tracks the driven latch state.
module latch_input_conditioner
    import latch_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_s,
    input  logic raw_r,
    input  logic raw_preset,
    input  logic raw_clr,
    output logic s_out,
    output logic r_out,
    output logic preset_out,
    output logic clr_out,
    output logic conflict,
    output logic q_model
);

    logic w_dS;
    logic w_dR;
    logic w_dPreset;
    logic w_dClr;

    logic r_sOut;
    logic r_rOut;
    logic r_presetOut;
    logic r_clrOut;
    logic r_conflict;
    logic r_q;

    debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chS (
        .clk(clk), .rst(rst), .raw(raw_s), .deb(w_dS)
    );
    debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chR (
        .clk(clk), .rst(rst), .raw(raw_r), .deb(w_dR)
    );
    debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chPreset (
        .clk(clk), .rst(rst), .raw(raw_preset), .deb(w_dPreset)
    );
    debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chClr (
        .clk(clk), .rst(rst), .raw(raw_clr), .deb(w_dClr)
    );

    // Clear dominates preset, both dominate set/reset; simultaneous set and reset means hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sOut      <= 1'b0;
            r_rOut      <= 1'b0;
            r_presetOut <= 1'b0;
            r_clrOut    <= 1'b0;
            r_conflict  <= 1'b0;
        end else begin
            r_clrOut    <= w_dClr;
            r_presetOut <= w_dPreset & ~w_dClr;
            r_sOut      <= w_dS & ~w_dR & ~w_dClr & ~w_dPreset;
            r_rOut      <= w_dR & ~w_dS & ~w_dClr & ~w_dPreset;
            r_conflict  <= w_dS & w_dR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= 1'b0;
        end else if (r_clrOut) begin
            r_q <= 1'b0;
        end else if (r_presetOut) begin
            r_q <= 1'b1;
        end else if (r_sOut) begin
            r_q <= 1'b1;
        end else if (r_rOut) begin
            r_q <= 1'b0;
        end
    end

    assign s_out      = r_sOut;
    assign r_out      = r_rOut;
    assign preset_out = r_presetOut;
    assign clr_out    = r_clrOut;
    assign conflict   = r_conflict;
    assign q_model    = r_q;

endmodule

// File: tb/tb_latch_input_conditioner.sv
// Self-checking bench: directed latency/priority scenarios plus random bounce against a history-based model.
module tb_latch_input_conditioner;

    localparam int N = 4;

    logic clk;
    logic rst;
    logic raw_s;
    logic raw_r;
    logic raw_preset;
    logic raw_clr;
    logic s_out;
    logic r_out;
    logic preset_out;
    logic clr_out;
    logic conflict;
    logic q_model;

    int checks;
    int errors;

    latch_input_conditioner #(.DEBOUNCE_CYCLES(N)) dut (
        .clk(clk),
        .rst(rst),
        .raw_s(raw_s),
        .raw_r(raw_r),
        .raw_preset(raw_preset),
        .raw_clr(raw_clr),
        .s_out(s_out),
        .r_out(r_out),
        .preset_out(preset_out),
        .clr_out(clr_out),
        .conflict(conflict),
        .q_model(q_model)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: channel order is 0=s, 1=r, 2=preset, 3=clr.
    logic [3:0] rawVec;
    logic       mPipe [4][2];
    logic       mHist [4][N];
    logic [3:0] mDeb;
    logic       mS, mR, mPre, mClr, mConf, mQ;
    bit         mValid;

    assign rawVec = {raw_clr, raw_preset, raw_r, raw_s};

    // Each channel's debounced value flips once the last N synchronized samples all disagree with it.
    always @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < 4; c++) begin
                mPipe[c][0] = 1'b0;
                mPipe[c][1] = 1'b0;
                for (int i = 0; i < N; i++) mHist[c][i] = 1'b0;
            end
            mDeb   = '0;
            mS     = 1'b0;
            mR     = 1'b0;
            mPre   = 1'b0;
            mClr   = 1'b0;
            mConf  = 1'b0;
            mQ     = 1'b0;
            mValid = 1'b1;
        end else begin
            if (mClr)      mQ = 1'b0;
            else if (mPre) mQ = 1'b1;
            else if (mS)   mQ = 1'b1;
            else if (mR)   mQ = 1'b0;
            mClr  = mDeb[3];
            mPre  = mDeb[2] && !mDeb[3];
            mS    = mDeb[0] && !mDeb[1] && !mDeb[3] && !mDeb[2];
            mR    = mDeb[1] && !mDeb[0] && !mDeb[3] && !mDeb[2];
            mConf = mDeb[0] && mDeb[1];
            for (int c = 0; c < 4; c++) begin
                logic seen;
                logic allDiff;
                seen        = mPipe[c][0];
                mPipe[c][0] = mPipe[c][1];
                mPipe[c][1] = rawVec[c];
                for (int i = 0; i < N - 1; i++) mHist[c][i] = mHist[c][i + 1];
                mHist[c][N - 1] = seen;
                allDiff = 1'b1;
                for (int i = 0; i < N; i++) if (mHist[c][i] == mDeb[c]) allDiff = 1'b0;
                if (allDiff) mDeb[c] = !mDeb[c];
            end
        end
    end

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, actual, expected);
        end
    endtask

    // Cycle-by-cycle comparison against the model, plus the exclusivity assertions.
    always @(negedge clk) begin
        if (mValid) begin
            checkOutput("model.s_out", s_out, mS);
            checkOutput("model.r_out", r_out, mR);
            checkOutput("model.preset_out", preset_out, mPre);
            checkOutput("model.clr_out", clr_out, mClr);
            checkOutput("model.conflict", conflict, mConf);
            checkOutput("model.q_model", q_model, mQ);
            checks++;
            assert (!(s_out && r_out)) else begin
                errors++;
                $display("[TB] FAIL excl_sr at %0t: s_out=%b r_out=%b, expected not both 1", $time, s_out, r_out);
            end
            checks++;
            assert (!(preset_out && clr_out)) else begin
                errors++;
                $display("[TB] FAIL excl_pc at %0t: preset_out=%b clr_out=%b, expected not both 1", $time, preset_out, clr_out);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic r, input logic p, input logic c);
        raw_s      = s;
        raw_r      = r;
        raw_preset = p;
        raw_clr    = c;
    endtask

    task automatic applyReset();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // Set step: raw_s first sampled at E0, s_out at E0+6, q_model at E0+7.
        applyReset();
        checkOutput("reset.q_model", q_model, 1'b0);
        checkOutput("reset.s_out", s_out, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int e = 0; e < 8; e++) begin
            tick();
            if (e < 6) checkOutput("set.s_out_early", s_out, 1'b0);
            if (e == 6) begin
                checkOutput("set.s_out", s_out, 1'b1);
                checkOutput("set.q_before", q_model, 1'b0);
            end
            if (e == 7) checkOutput("set.q_model", q_model, 1'b1);
        end

        // Glitch: three samples of raw_r never reach the debounce count.
        applyReset();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        for (int e = 0; e < 10; e++) begin
            tick();
            checkOutput("glitch.r_out", r_out, 1'b0);
            checkOutput("glitch.q_model", q_model, 1'b0);
        end

        // Conflict: both set and reset held.
        applyReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int e = 0; e < 10; e++) begin
            tick();
            if (e == 5) checkOutput("conflict.early", conflict, 1'b0);
            if (e >= 6) checkOutput("conflict.high", conflict, 1'b1);
            checkOutput("conflict.s_out", s_out, 1'b0);
            checkOutput("conflict.r_out", r_out, 1'b0);
            checkOutput("conflict.q_hold", q_model, 1'b0);
        end

        // Priority: clear beats preset; releasing clear lets preset through six edges later.
        applyReset();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        for (int e = 0; e < 9; e++) tick();
        checkOutput("prio.clr_out", clr_out, 1'b1);
        checkOutput("prio.preset_out", preset_out, 1'b0);
        checkOutput("prio.q_model", q_model, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        for (int e = 0; e < 8; e++) begin
            tick();
            if (e == 5) checkOutput("prio.preset_early", preset_out, 1'b0);
            if (e == 6) begin
                checkOutput("prio.preset_out", preset_out, 1'b1);
                checkOutput("prio.clr_released", clr_out, 1'b0);
            end
            if (e == 7) checkOutput("prio.q_preset", q_model, 1'b1);
        end

        // Reset mid-count: the count restarts from the first post-reset sampling edge.
        applyReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int e = 0; e < 8; e++) begin
            tick();
            if (e < 6) checkOutput("midreset.s_early", s_out, 1'b0);
            if (e == 6) checkOutput("midreset.s_out", s_out, 1'b1);
        end

        // Random bounce with occasional resets.
        applyReset();
        for (int k = 0; k < 10000; k++) begin
            if ($urandom_range(0, 7) == 0) raw_s      = ~raw_s;
            if ($urandom_range(0, 7) == 0) raw_r      = ~raw_r;
            if ($urandom_range(0, 7) == 0) raw_preset = ~raw_preset;
            if ($urandom_range(0, 7) == 0) raw_clr    = ~raw_clr;
            rst = ($urandom_range(0, 999) == 0);
            tick();
        end
        rst = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
